// File: rtl/softmax_bwd.sv
// Streaming softmax backward pass: dx_i = y_i * (dy_i - sum_j y_j*dy_j), buffered per vector.
// Define SOFTMAX_BWD_SAT_EN to saturate s and dx; otherwise the rounded values wrap to DATA_W bits.
module softmax_bwd #(
  parameter int unsigned SIZE   = 128,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_y,
  input  logic [DATA_W-1:0] in_dy,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_dx,
  output logic              out_last,
  output logic              err
);

  localparam int unsigned IDX_W  = $clog2(SIZE);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned ACC_W  = PROD_W + IDX_W;

  // Rounding datapath widths: full precision when saturating, only the surviving low bits when wrapping
`ifdef SOFTMAX_BWD_SAT_EN
  localparam int unsigned SA_W = ACC_W + 1;
  localparam int unsigned SP_W = 2 * DATA_W + 2;
`else
  localparam int unsigned SA_W = DATA_W + FRAC;
  localparam int unsigned SP_W = DATA_W + FRAC;
`endif
  localparam int unsigned RA_W = SA_W - FRAC;
  localparam int unsigned RP_W = SP_W - FRAC;

  localparam logic signed [SA_W-1:0] HALF_A = SA_W'(1) << (FRAC - 1);
  localparam logic signed [SP_W-1:0] HALF_P = SP_W'(1) << (FRAC - 1);

`ifdef SOFTMAX_BWD_SAT_EN
  localparam logic signed [RA_W-1:0] SAT_MAX = RA_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [RA_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_FINAL = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;

  // Narrow a rounded value to DATA_W bits
  function automatic logic [DATA_W-1:0] reduce_w(input logic signed [RA_W-1:0] v);
`ifdef SOFTMAX_BWD_SAT_EN
    if (v > SAT_MAX) begin
      reduce_w = DATA_W'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      reduce_w = DATA_W'(SAT_MIN);
    end else begin
      reduce_w = DATA_W'(v);
    end
`else
    reduce_w = DATA_W'(v);
`endif
  endfunction

  logic [1:0]               state_q, state_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         last_idx_q, last_idx_d;
  logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        s_q, s_d;
  logic                     err_q, err_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_dx_q, out_dx_d;
  logic                     out_last_q, out_last_d;
  logic                     wr_en_c;

  logic [DATA_W-1:0]        buf_y  [SIZE];
  logic [DATA_W-1:0]        buf_dy [SIZE];

  logic signed [PROD_W-1:0] mac_prod;
  logic signed [SA_W-1:0]   acc_ext;
  logic signed [SA_W-1:0]   acc_rnd;
  logic signed [RA_W-1:0]   s_wide;
  logic [DATA_W-1:0]        s_c;
  logic [DATA_W-1:0]        s_use;
  logic [DATA_W-1:0]        rd_y;
  logic [DATA_W-1:0]        rd_dy;
  logic signed [DATA_W:0]   diff;
  logic signed [SP_W-1:0]   prod;
  logic signed [SP_W-1:0]   prod_rnd;
  logic signed [RP_W-1:0]   dx_wide;
  logic [DATA_W-1:0]        dx_c;

  assign mac_prod = PROD_W'($signed(in_y)) * PROD_W'($signed(in_dy));

  // s = round-half-up(acc / 2^FRAC)
  assign acc_ext = SA_W'(acc_q);
  assign acc_rnd = acc_ext + HALF_A;
  assign s_wide  = RA_W'(acc_rnd >>> FRAC);
  assign s_c     = reduce_w(s_wide);

  // FINAL produces dx_0 from the freshly rounded s so the first result lands one cycle later
  assign s_use    = (state_q == ST_FINAL) ? s_c : s_q;
  assign rd_y     = buf_y[rd_idx_q];
  assign rd_dy    = buf_dy[rd_idx_q];
  assign diff     = (DATA_W + 1)'($signed(rd_dy)) - (DATA_W + 1)'($signed(s_use));
  assign prod     = SP_W'($signed(rd_y)) * SP_W'(diff);
  assign prod_rnd = prod + HALF_P;
  assign dx_wide  = RP_W'(prod_rnd >>> FRAC);
  assign dx_c     = reduce_w(RA_W'(dx_wide));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_idx_d  = last_idx_q;
    rd_idx_d    = rd_idx_q;
    acc_d       = acc_q;
    s_d         = s_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_dx_d    = out_dx_q;
    out_last_d  = out_last_q;
    wr_en_c     = 1'b0;

    case (state_q)
      ST_LOAD: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          wr_en_c = 1'b1;
          acc_d   = acc_q + ACC_W'(mac_prod);
          if (in_last || (cnt_q == IDX_W'(SIZE - 1))) begin
            state_d    = ST_FINAL;
            last_idx_d = cnt_q;
            cnt_d      = '0;
            rd_idx_d   = '0;
            in_ready_d = 1'b0;
            if (!in_last) begin
              err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end

      ST_FINAL: begin
        s_d         = s_c;
        acc_d       = '0;
        out_valid_d = 1'b1;
        out_dx_d    = dx_c;
        out_last_d  = (last_idx_q == '0);
        rd_idx_d    = rd_idx_q + IDX_W'(1);
        state_d     = ST_EMIT;
      end

      ST_EMIT: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_LOAD;
          end else begin
            out_dx_d   = dx_c;
            out_last_d = (rd_idx_q == last_idx_q);
            rd_idx_d   = rd_idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      last_idx_q  <= '0;
      rd_idx_q    <= '0;
      acc_q       <= '0;
      s_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_dx_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_idx_q  <= last_idx_d;
      rd_idx_q    <= rd_idx_d;
      acc_q       <= acc_d;
      s_q         <= s_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_dx_q    <= out_dx_d;
      out_last_q  <= out_last_d;
    end
  end

  // Element buffer; contents need no reset since cnt/len gate every read
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      buf_y[cnt_q]  <= in_y;
      buf_dy[cnt_q] <= in_dy;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_dx    = out_dx_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

endmodule

// File: doc/softmax_bwd.md
# softmax_bwd

Streaming backward pass for the softmax layer: computes dx_i = y_i · (dy_i − Σ_j y_j·dy_j) from the forward softmax output y and the upstream gradient dy. Element pairs (y_i, dy_i) stream in over a valid/ready port, are buffered, and the dot product is accumulated on the fly. Results then stream out over a second valid/ready port. Sits in the training datapath directly behind the attention-score gradient stage, mirroring the forward softmax block.

## Interface
- SIZE, 128: maximum vector length (power of two, ≥2)
- DATA_W, 16: element width; signed two's complement, Q(DATA_W−FRAC).FRAC
- FRAC, 12: fractional bits (Q4.12 at defaults; 1.0 = 0x1000)
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input pair valid
- in_ready  out  1  block accepts a pair
- in_y  in  DATA_W  softmax output y_i
- in_dy  in  DATA_W  upstream gradient dy_i
- in_last  in  1  marks final element of the vector
- out_valid  out  1  dx element valid
- out_ready  in  1  consumer accepts dx
- out_dx  out  DATA_W  gradient dx_i
- out_last  out  1  marks final dx of the vector
- err  out  1  sticky: vector overran SIZE without in_last

## Operation
- States: LOAD → FINAL → EMIT → LOAD.
- LOAD: in_ready=1. On each handshake write (y,dy) to buffer[cnt], acc += y·dy (full 2·DATA_W product, accumulator 2·DATA_W+log2(SIZE) bits), cnt++. Handshake with in_last, or handshake at cnt=SIZE−1, latches len=cnt+1 and moves to FINAL. Reaching SIZE−1 without in_last sets err; subsequent pairs belong to the next vector.
- FINAL (1 cycle): in_ready=0; s = round(acc >>> FRAC), round half up (add 2^(FRAC−1) before shift), saturated to DATA_W bits. acc cleared.
- EMIT: in_ready=0. For idx 0..len−1: d = y_idx − … precisely d = dy_idx − s in DATA_W+1 bits; p = y_idx·d; dx = round(p >>> FRAC) reduced to DATA_W bits per Configuration. out_last=1 on idx=len−1. After out_last handshake return to LOAD, cnt=0.
- One-stage output register: out_valid/out_dx/out_last hold stable while out_valid=1 and out_ready=0; next element loads on the same cycle as a handshake (full throughput).
- Vector length 1 legal: s = y·dy, dx = y·(dy−s).
- Reset at any point: partial vector discarded, acc/cnt cleared, state LOAD.
- Reset values: in_ready=0 (during reset cycle, 1 the following cycle), out_valid=0, out_dx=0, out_last=0, err=0.

## Timing
- Input throughput 1 pair/cycle in LOAD.
- Last input handshake at cycle T → FINAL at T+1 → out_valid=1 with dx_0 at T+2.
- With out_ready held high: dx_k valid at T+2+k; LOAD re-entered (in_ready=1) at cycle T+2+len.
- Output backpressure stalls only EMIT; no input accepted until the whole vector has drained.
- err set in the cycle after the overrunning handshake; cleared only by rst.

## Configuration
- SOFTMAX_BWD_SAT_EN defined: s and every dx saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1] on overflow.
- Not defined: s and dx keep the low DATA_W bits of the rounded value (wrap); no saturation logic is generated.

## Test plan
- Basic: SIZE≥2, y=[0x0800,0x0800], dy=[0x1000,0x0000], in_last on 2nd → s=0x0800; out_dx=[0x0400,0xFC00], out_last on 2nd, first out_valid 2 cycles after last input.
- Backpressure: same vector, out_ready toggled 1,0,0,1 → out_dx/out_last stable while stalled, exactly 2 output handshakes, in_ready=0 until the second.
- Overrun: send SIZE pairs of y=0x1000, dy=0x0000 with no in_last → err=1 the cycle after the SIZE-th pair, SIZE outputs of 0x0000, out_last on the SIZE-th.
- Saturation (SAT_EN): y=[0x7FFF,0x7FFF], dy=[0x7FFF,0x8000] → s=0xFFF8, dx_0=0x7FFF (saturated); without macro dx_0 equals the low 16 bits of the rounded product.
- Reset mid-operation: rst for 1 cycle after 3 of 5 inputs → out_valid=0, err=0; a fresh length-1 vector y=0x1000, dy=0x1000 yields s=0x1000, dx=0x0000.
- Back-to-back vectors at full rate: two vectors of length 4 with out_ready=1 → outputs contiguous per vector, second vector's first input accepted the cycle after first vector's out_last.
